// File: rtl/dmem_arbiter_if.sv
// Bundle of both master ports (A: CPU, B: DMA/debug) and the shared 32x8 memory pins.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              a_req;
    logic              a_we;
    logic              a_lock;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic              b_lock;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side: takes requests from both masters, drives the memory pins.
    modport slave (
        input  a_req, a_we, a_lock, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_lock, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_en, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Environment side: masters and memory.
    modport master (
        output a_req, a_we, a_lock, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_lock, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_en, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter for the shared data memory, with lock for atomic RMW.
// One access is issued per cycle; read data returns one cycle after the issue cycle.
module dmem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} owner_t;

    owner_t            owner;
    logic              last_gnt_b;   // 1 = B granted last, so A is preferred on a tie
    logic              issue_valid;
    logic              issue_port;   // 0 = A, 1 = B
    logic              arb_free;
    logic              sel_a;
    logic              sel_b;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Grant selection; a lock owner that drops both req and lock releases in the same
    // cycle, so the other port may be granted immediately.
    always_comb begin
        arb_free = (owner == IDLE)
                 || (owner == OWN_A && !bus.a_req && !bus.a_lock)
                 || (owner == OWN_B && !bus.b_req && !bus.b_lock);
        sel_a = 1'b0;
        sel_b = 1'b0;
        if (arb_free) begin
            if (bus.a_req && bus.b_req) begin
                sel_a = last_gnt_b;
                sel_b = !last_gnt_b;
            end else begin
                sel_a = bus.a_req;
                sel_b = bus.b_req;
            end
        end else if (owner == OWN_A) begin
            sel_a = bus.a_req;
        end else begin
            sel_b = bus.b_req;
        end
        bus.a_gnt = sel_a;
        bus.b_gnt = sel_b;
        sel_we    = sel_b ? bus.b_we    : bus.a_we;
        sel_addr  = sel_b ? bus.b_addr  : bus.a_addr;
        sel_wdata = sel_b ? bus.b_wdata : bus.a_wdata;
    end

    // Owner FSM and round-robin pointer.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            owner      <= IDLE;
            last_gnt_b <= 1'b1;
        end else if (sel_a) begin
            owner      <= bus.a_lock ? OWN_A : IDLE;
            last_gnt_b <= 1'b0;
        end else if (sel_b) begin
            owner      <= bus.b_lock ? OWN_B : IDLE;
            last_gnt_b <= 1'b1;
        end else if (arb_free) begin
            owner      <= IDLE;
        end
    end

    // Issue stage registers the granted command; completion stage captures read data.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            issue_valid   <= 1'b0;
            issue_port    <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.a_rvalid  <= 1'b0;
            bus.a_rdata   <= '0;
            bus.b_rvalid  <= 1'b0;
            bus.b_rdata   <= '0;
        end else begin
            if (sel_a || sel_b) begin
                issue_valid   <= 1'b1;
                issue_port    <= sel_b;
                bus.mem_en    <= sel_we;
                bus.mem_addr  <= sel_addr;
                bus.mem_wdata <= sel_wdata;
            end else begin
                issue_valid   <= 1'b0;
                bus.mem_en    <= 1'b0;
            end

            bus.a_rvalid <= issue_valid && !bus.mem_en && !issue_port;
            bus.b_rvalid <= issue_valid && !bus.mem_en &&  issue_port;
            if (issue_valid && !bus.mem_en && !issue_port)
                bus.a_rdata <= bus.mem_rdata;
            if (issue_valid && !bus.mem_en && issue_port)
                bus.b_rdata <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a 32x8 memory model (all locations start at 0xFF).
module tb_dmem_arbiter;
    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    dmem_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    dmem_arbiter #(.ADDR_W(5), .DATA_W(8)) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    logic [7:0] mem [32] = '{default: 8'hFF};

    always @(posedge Clk) if (bus.mem_en) mem[bus.mem_addr] <= bus.mem_wdata;
    assign bus.mem_rdata = mem[bus.mem_addr];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic half();
        @(negedge Clk);
    endtask

    initial begin
        logic exp_a;
        checks = 0;
        errors = 0;
        Reset = 1'b0;
        bus.a_req = 0; bus.a_we = 0; bus.a_lock = 0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_lock = 0; bus.b_addr = '0; bus.b_wdata = '0;

        // Reset state
        #2;
        check_eq("rst_mem_en",    32'(bus.mem_en),    0);
        check_eq("rst_mem_addr",  32'(bus.mem_addr),  0);
        check_eq("rst_mem_wdata", 32'(bus.mem_wdata), 0);
        check_eq("rst_a_rvalid",  32'(bus.a_rvalid),  0);
        check_eq("rst_b_rvalid",  32'(bus.b_rvalid),  0);
        check_eq("rst_a_rdata",   32'(bus.a_rdata),   0);
        check_eq("rst_b_rdata",   32'(bus.b_rdata),   0);
        half();
        Reset = 1'b1;
        step();

        // B read @0x1B after reset
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 5'h1B;
        half();
        check_eq("t4_b_gnt", 32'(bus.b_gnt), 1);
        check_eq("t4_a_gnt", 32'(bus.a_gnt), 0);
        step();
        bus.b_req = 0;
        check_eq("t4_mem_addr", 32'(bus.mem_addr), 32'h1B);
        check_eq("t4_mem_en",   32'(bus.mem_en),   0);
        step();
        check_eq("t4_b_rvalid", 32'(bus.b_rvalid), 1);
        check_eq("t4_b_rdata",  32'(bus.b_rdata),  32'hFF);
        check_eq("t4_a_rvalid", 32'(bus.a_rvalid), 0);
        step();
        check_eq("t4_b_rvalid_end", 32'(bus.b_rvalid), 0);

        // A write 0x3C @0x05 then A read @0x05
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 5'h05; bus.a_wdata = 8'h3C;
        half();
        check_eq("t2_wr_gnt", 32'(bus.a_gnt), 1);
        step();
        check_eq("t2_mem_en",    32'(bus.mem_en),    1);
        check_eq("t2_mem_addr",  32'(bus.mem_addr),  5);
        check_eq("t2_mem_wdata", 32'(bus.mem_wdata), 32'h3C);
        bus.a_we = 0;
        half();
        check_eq("t2_rd_gnt", 32'(bus.a_gnt), 1);
        step();
        bus.a_req = 0;
        check_eq("t2_mem_en_rd", 32'(bus.mem_en),   0);
        check_eq("t2_rv_early",  32'(bus.a_rvalid), 0);
        check_eq("t2_mem5",      32'(mem[5]),       32'h3C);
        step();
        check_eq("t2_a_rvalid", 32'(bus.a_rvalid), 1);
        check_eq("t2_a_rdata",  32'(bus.a_rdata),  32'h3C);
        step();
        check_eq("t2_a_rvalid_end", 32'(bus.a_rvalid), 0);
        check_eq("t2_mem_en_idle",  32'(bus.mem_en),   0);

        // Back to reset so A is preferred, then both request continuously
        Reset = 1'b0;
        #2;
        Reset = 1'b1;
        step();
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 5'h05;
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 5'h1B;
        for (int i = 0; i < 6; i++) begin
            half();
            exp_a = (i % 2 == 0);
            check_eq($sformatf("t3_a_gnt%0d", i), 32'(bus.a_gnt), 32'(exp_a));
            check_eq($sformatf("t3_b_gnt%0d", i), 32'(bus.b_gnt), 32'(!exp_a));
            if (i >= 2) begin
                check_eq($sformatf("t3_a_rv%0d", i), 32'(bus.a_rvalid), 32'(exp_a));
                check_eq($sformatf("t3_b_rv%0d", i), 32'(bus.b_rvalid), 32'(!exp_a));
                if (exp_a) check_eq($sformatf("t3_a_rd%0d", i), 32'(bus.a_rdata), 32'h3C);
                else       check_eq($sformatf("t3_b_rd%0d", i), 32'(bus.b_rdata), 32'hFF);
            end
            step();
        end
        bus.a_req = 0; bus.b_req = 0;
        step();
        step();

        // A locked read-modify-write @0x02 with B requesting throughout
        bus.a_req = 1; bus.a_lock = 1; bus.a_we = 0; bus.a_addr = 5'h02;
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 5'h03;
        half();
        check_eq("t5_rd_a_gnt", 32'(bus.a_gnt), 1);
        check_eq("t5_rd_b_gnt", 32'(bus.b_gnt), 0);
        step();
        bus.a_req = 0;
        half();
        check_eq("t5_gap_a_gnt", 32'(bus.a_gnt), 0);
        check_eq("t5_gap_b_gnt", 32'(bus.b_gnt), 0);
        step();
        check_eq("t5_a_rvalid", 32'(bus.a_rvalid), 1);
        check_eq("t5_a_rdata",  32'(bus.a_rdata),  32'hFF);
        bus.a_req = 1; bus.a_we = 1; bus.a_wdata = 8'h11; bus.a_lock = 0;
        half();
        check_eq("t5_wr_a_gnt", 32'(bus.a_gnt), 1);
        check_eq("t5_wr_b_gnt", 32'(bus.b_gnt), 0);
        step();
        bus.a_req = 0; bus.a_we = 0;
        half();
        check_eq("t5_b_after", 32'(bus.b_gnt), 1);
        step();
        bus.b_req = 0;
        step();
        check_eq("t5_mem2", 32'(mem[2]), 32'h11);

        // Lock released without a grant hands over in the same cycle
        bus.a_req = 1; bus.a_lock = 1; bus.a_addr = 5'h07;
        bus.b_req = 1; bus.b_addr = 5'h03;
        half();
        check_eq("t6_a_gnt", 32'(bus.a_gnt), 1);
        check_eq("t6_b_gnt", 32'(bus.b_gnt), 0);
        step();
        bus.a_req = 0; bus.a_lock = 0;
        half();
        check_eq("t6_rel_b_gnt", 32'(bus.b_gnt), 1);
        check_eq("t6_rel_a_gnt", 32'(bus.a_gnt), 0);
        step();
        bus.b_req = 0;
        step();
        step();
        check_eq("t6_a_rdata", 32'(bus.a_rdata), 32'hFF);

        // Reset asserted while an A read is in flight
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 5'h05;
        half();
        check_eq("t1_a_gnt", 32'(bus.a_gnt), 1);
        step();
        bus.a_req = 0;
        check_eq("t1_pre_addr", 32'(bus.mem_addr), 5);
        #1;
        Reset = 1'b0;
        #1;
        check_eq("t1_mem_addr",  32'(bus.mem_addr),  0);
        check_eq("t1_mem_wdata", 32'(bus.mem_wdata), 0);
        check_eq("t1_mem_en",    32'(bus.mem_en),    0);
        check_eq("t1_a_rdata",   32'(bus.a_rdata),   0);
        check_eq("t1_b_rdata",   32'(bus.b_rdata),   0);
        check_eq("t1_a_rvalid",  32'(bus.a_rvalid),  0);
        step();
        check_eq("t1_rv_in_rst", 32'(bus.a_rvalid), 0);
        half();
        Reset = 1'b1;
        step();
        check_eq("t1_rv_after1", 32'(bus.a_rvalid), 0);
        step();
        check_eq("t1_rv_after2", 32'(bus.a_rvalid), 0);
        check_eq("t1_mem5",      32'(mem[5]),       32'h3C);
        check_eq("t1_mem2",      32'(mem[2]),       32'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
